colorshield_scan_ctrl: RTL
==========================

# colorshield_scan_ctrl

Row-scan controller for the DM163-based colorshield 8x8 RGB matrix. After reset it pulses the shield reset and loads DM163 bank 0 with a fixed 6-bit correction value. It then repeatedly fetches one row of 24-bit pixels from a pixel memory, shifts the row serially into the DM163, latches it and lights the row for a fixed dwell. It sits between the frame buffer and the shield pins, and is the sequencer that the shield-side signal sampling logic is timed against.

## Interface
- CLK_DIV, 2: clk cycles per SCK half-period (≥1)
- ROW_HOLD, 2000: clk cycles a row stays lit (≥1)
- RST_CYCLES, 8: clk cycles shield_rst_n is held low after reset
- BANK0_VAL, 6'h3F: value written to all 24 bank-0 channels

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  run row scanning while high
- pix_addr  out  6  pixel memory address {row[2:0], col[2:0]}
- pix_data  in  24  {R[23:16], G[15:8], B[7:0]}; valid one cycle after pix_addr
- shield_rst_n  out  1  DM163 RST, active low
- sck  out  1  DM163 serial clock
- sda  out  1  DM163 serial data
- lat  out  1  DM163 latch
- sb  out  1  bank select; 0 = bank 0, 1 = bank 1
- channel  out  8  one-hot row drive, active high
- init_done  out  1  high once bank-0 init has finished; sticky until rst
- row_done  out  1  one-cycle pulse when a row's dwell ends
- frame_done  out  1  one-cycle pulse when row 7's dwell ends

## Operation
- States: SHRST → B0_SHIFT → B0_LATCH → IDLE → FETCH → SHIFT → LATCH → DISPLAY.
- Reset values:
  - shield_rst_n=0, sck=0, sda=0, lat=0, sb=0, channel=0, pix_addr=0.
  - init_done=0, row_done=0, frame_done=0, row counter=0, state=SHRST.
- SHRST: hold shield_rst_n=0 for RST_CYCLES cycles, then drive it to 1 and enter B0_SHIFT.
- B0_SHIFT: sb=0. Shift 144 bits: BANK0_VAL MSB-first, repeated 24 times.
- B0_LATCH: lat=1 for one cycle. Next cycle: sb=1, init_done=1, go to IDLE.
- IDLE:
  - channel=0.
  - If enable=1, go to FETCH for the current row.
- FETCH:
  - Drive pix_addr={row, col}.
  - Capture pix_data on the following cycle (2 cycles per pixel).
  - Then go to SHIFT.
- SHIFT:
  - Shift 24 bits MSB-first (bit 23 first).
  - Columns are processed in order 7 down to 0, alternating with FETCH, giving 192 bits per row.
  - channel=0 throughout FETCH, SHIFT and LATCH (blanking).
- LATCH: lat=1 for exactly one cycle. Then channel=1<<row and enter DISPLAY.
- DISPLAY: hold channel for ROW_HOLD cycles.
  - Final cycle: channel→0 and row_done=1.
  - If row=7, also frame_done=1 and row wraps to 0; otherwise row increments.
  - Then go to FETCH if enable=1, else IDLE.
- enable is sampled only in IDLE and at the end of DISPLAY. Deassertion mid-row completes that row's dwell.
- rst asserted in any state: all outputs take their reset values on the next edge, and the init sequence restarts.

## Timing
- Bit cell is 2*CLK_DIV cycles.
  - sda changes on the same edge that sck falls, or on cell entry.
  - sck is low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - The DM163 samples sda on the sck rise.
  - sck returns to 0 at the end of every cell. sck is 0 outside the shift states.
- Row cycle = 8*(2 + 48*CLK_DIV) + 1 (LATCH) + ROW_HOLD cycles. This is 2785 cycles at defaults.
- Init length:
  - RST_CYCLES + 288*CLK_DIV + 1 cycles from rst deassertion to the B0_LATCH pulse.
  - init_done rises one cycle after that pulse.
- lat never coincides with sck=1.
- Neither lat nor any sck pulse occurs while channel≠0.

## Test plan
- **Init:** release rst with defaults.
  - shield_rst_n stays low for exactly 8 cycles.
  - Then 144 sck rising edges, each sampling sda=1, with sb=0.
  - Then one lat pulse, then sb=1 and init_done=1.
- **Row shift:** load memory with data = {addr, addr, addr} (addr zero-extended to 8 bits) and set enable=1.
  - The 192 bits captured at sck rises for row 0 are cols 7..0 of {R,G,B}, MSB-first, matching the memory contents.
- **Row dwell:** after the row-0 lat pulse, channel=8'h01 for exactly ROW_HOLD cycles.
  - row_done pulses on the last of those cycles.
  - channel=0 during the next FETCH.
- **Frame wrap:** run 8 rows.
  - channel sequences 01, 02, … 80.
  - frame_done pulses once, together with the row-7 row_done.
  - The next FETCH presents pix_addr=0.
- **Enable drop:** deassert enable mid-SHIFT of row 3.
  - Row 3 still shifts, latches and displays (channel=8'h08).
  - The block then sits in IDLE with channel=0.
  - Reasserting enable resumes at row 4.
- **Mid-operation reset:** assert rst for one cycle during row 5 DISPLAY.
  - The next cycle shows channel=0, init_done=0, shield_rst_n=0.
  - The full init sequence repeats, and scanning restarts at row 0.

Source files
------------

// File: rtl/colorshield_scan_ctrl.sv
// colorshield_scan_ctrl: DM163 row-scan sequencer for the 8x8 RGB shield.
// Pulses shield reset, loads bank 0 with BANK0_VAL, then fetches each row
// of 24-bit pixels (cols 7..0), shifts them MSB-first, latches, and lights
// the row for ROW_HOLD cycles.
// Ports:
//   clk, rst           system clock, sync active-high reset
//   enable             run row scanning (sampled in IDLE / end of dwell)
//   pix_addr, pix_data pixel memory {row,col}; data one cycle after addr
//   shield_rst_n, sck, sda, lat, sb  DM163 pins
//   channel            one-hot active-high row drive
//   init_done, row_done, frame_done  status
module colorshield_scan_ctrl #(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned ROW_HOLD   = 2000,
  parameter int unsigned RST_CYCLES = 8,
  parameter logic [5:0]  BANK0_VAL  = 6'h3F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic [5:0]  pix_addr,
  input  logic [23:0] pix_data,
  output logic        shield_rst_n,
  output logic        sck,
  output logic        sda,
  output logic        lat,
  output logic        sb,
  output logic [7:0]  channel,
  output logic        init_done,
  output logic        row_done,
  output logic        frame_done
);

  localparam int unsigned CELL = 2 * CLK_DIV;
  localparam int unsigned PW   = (CELL > 2) ? $clog2(CELL) : 1;
  localparam int unsigned CMAX =
    (ROW_HOLD > RST_CYCLES) ? ROW_HOLD : RST_CYCLES;
  localparam int unsigned CW   = $clog2(CMAX + 1);

  localparam logic [PW-1:0] PH_RISE   = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PH_END    = PW'(CELL - 1);
  localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(ROW_HOLD - 1);
  localparam logic [CW-1:0] HOLD_PRE  = CW'(ROW_HOLD - 2);
  localparam logic          HOLD_ONE  = (ROW_HOLD == 1);
  // 24 bits hold four copies of the 6-bit value, so six reloads give
  // the 144 bank-0 bits with the pattern staying in phase.
  localparam logic [23:0]   B0_WORD   = {4{BANK0_VAL}};

  typedef enum logic [2:0] {
    ST_SHRST,
    ST_B0_SHIFT,
    ST_B0_LATCH,
    ST_IDLE,
    ST_FETCH,
    ST_SHIFT,
    ST_LATCH,
    ST_DISPLAY
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [PW-1:0] ph_q;
  logic [4:0]    bit_q;
  logic [2:0]    idx_q;
  logic [2:0]    row_q;
  logic          fsel_q;
  logic [23:0]   sh_q;

  logic [5:0]    pix_addr_q;
  logic          shield_rst_n_q;
  logic          sck_q;
  logic          sda_q;
  logic          lat_q;
  logic          sb_q;
  logic [7:0]    channel_q;
  logic          init_done_q;
  logic          row_done_q;
  logic          frame_done_q;

  logic cell_rise;
  logic cell_end;
  logic last_bit;

  assign cell_rise = (ph_q == PH_RISE);
  assign cell_end  = (ph_q == PH_END);
  assign last_bit  = (bit_q == 5'd23);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_SHRST;
      cnt_q          <= '0;
      ph_q           <= '0;
      bit_q          <= '0;
      idx_q          <= '0;
      row_q          <= '0;
      fsel_q         <= 1'b0;
      sh_q           <= '0;
      pix_addr_q     <= '0;
      shield_rst_n_q <= 1'b0;
      sck_q          <= 1'b0;
      sda_q          <= 1'b0;
      lat_q          <= 1'b0;
      sb_q           <= 1'b0;
      channel_q      <= '0;
      init_done_q    <= 1'b0;
      row_done_q     <= 1'b0;
      frame_done_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_SHRST: begin
          if (cnt_q == RST_LAST) begin
            shield_rst_n_q <= 1'b1;
            sh_q           <= B0_WORD;
            sda_q          <= B0_WORD[23];
            ph_q           <= '0;
            bit_q          <= '0;
            idx_q          <= '0;
            state_q        <= ST_B0_SHIFT;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        ST_B0_SHIFT: begin
          if (cell_end) begin
            sck_q <= 1'b0;
            ph_q  <= '0;
            if (!last_bit) begin
              bit_q <= bit_q + 5'd1;
              sh_q  <= sh_q << 1;
              sda_q <= sh_q[22];
            end else if (idx_q == 3'd5) begin
              lat_q   <= 1'b1;
              state_q <= ST_B0_LATCH;
            end else begin
              idx_q <= idx_q + 3'd1;
              bit_q <= '0;
              sh_q  <= B0_WORD;
              sda_q <= B0_WORD[23];
            end
          end else begin
            ph_q <= ph_q + PW'(1);
            if (cell_rise) sck_q <= 1'b1;
          end
        end

        ST_B0_LATCH: begin
          lat_q       <= 1'b0;
          sb_q        <= 1'b1;
          init_done_q <= 1'b1;
          state_q     <= ST_IDLE;
        end

        ST_IDLE: begin
          if (enable) begin
            pix_addr_q <= {row_q, 3'd7};
            idx_q      <= 3'd7;
            fsel_q     <= 1'b0;
            state_q    <= ST_FETCH;
          end
        end

        ST_FETCH: begin
          // first cycle presents the address, second captures the data
          if (!fsel_q) begin
            fsel_q <= 1'b1;
          end else begin
            sh_q    <= pix_data;
            sda_q   <= pix_data[23];
            ph_q    <= '0;
            bit_q   <= '0;
            state_q <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          if (cell_end) begin
            sck_q <= 1'b0;
            ph_q  <= '0;
            if (!last_bit) begin
              bit_q <= bit_q + 5'd1;
              sh_q  <= sh_q << 1;
              sda_q <= sh_q[22];
            end else if (idx_q == 3'd0) begin
              lat_q   <= 1'b1;
              state_q <= ST_LATCH;
            end else begin
              idx_q      <= idx_q - 3'd1;
              pix_addr_q <= {row_q, idx_q - 3'd1};
              fsel_q     <= 1'b0;
              state_q    <= ST_FETCH;
            end
          end else begin
            ph_q <= ph_q + PW'(1);
            if (cell_rise) sck_q <= 1'b1;
          end
        end

        ST_LATCH: begin
          lat_q        <= 1'b0;
          channel_q    <= 8'd1 << row_q;
          cnt_q        <= '0;
          row_done_q   <= HOLD_ONE;
          frame_done_q <= HOLD_ONE && (row_q == 3'd7);
          state_q      <= ST_DISPLAY;
        end

        ST_DISPLAY: begin
          if (cnt_q == HOLD_LAST) begin
            channel_q    <= '0;
            row_done_q   <= 1'b0;
            frame_done_q <= 1'b0;
            row_q        <= row_q + 3'd1;
            if (enable) begin
              pix_addr_q <= {row_q + 3'd1, 3'd7};
              idx_q      <= 3'd7;
              fsel_q     <= 1'b0;
              state_q    <= ST_FETCH;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
            // status pulses coincide with the last lit cycle
            if (cnt_q == HOLD_PRE) begin
              row_done_q   <= 1'b1;
              frame_done_q <= (row_q == 3'd7);
            end
          end
        end
      endcase
    end
  end

  assign pix_addr     = pix_addr_q;
  assign shield_rst_n = shield_rst_n_q;
  assign sck          = sck_q;
  assign sda          = sda_q;
  assign lat          = lat_q;
  assign sb           = sb_q;
  assign channel      = channel_q;
  assign init_done    = init_done_q;
  assign row_done     = row_done_q;
  assign frame_done   = frame_done_q;

endmodule
